// File: rtl/shared_reg_arbiter.sv
// rtl/shared_reg_arbiter.sv - round-robin owner of one shared DW-bit register with hold watchdog
module shared_reg_arbiter #(
  parameter int DW       = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [3:0]      req,
  input  logic [4*DW-1:0] din,
  output logic [3:0]      gnt,
  output logic [1:0]      owner,
  output logic [DW-1:0]   q,
  output logic            q_vld,
  output logic            busy
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } state_e;

  // Last legal hold_cnt value; reaching it while requested forces a release.
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_e          state_q, state_d;
  logic [3:0]      gnt_q, gnt_d;
  logic [1:0]      owner_q, owner_d;
  logic [DW-1:0]   q_q, q_d;
  logic            q_vld_q, q_vld_d;
  logic [1:0]      ptr_q, ptr_d;
  logic [7:0]      hold_cnt_q, hold_cnt_d;

  logic            win_found;
  logic [1:0]      win_idx;
  logic [1:0]      scan_idx;
  logic [DW-1:0]   owner_din;

  // Find the first active requester starting from the round-robin pointer.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    scan_idx  = ptr_q;
    for (int i = 0; i < 4; i++) begin
      scan_idx = ptr_q + 2'(i);
      if (!win_found && req[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  // Data lane belonging to the current owner.
  always_comb begin
    owner_din = din[int'(owner_q)*DW +: DW];
  end

  // Next-state logic: grant in IDLE, load/count/release in OWN.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    owner_d    = owner_q;
    q_d        = q_q;
    q_vld_d    = q_vld_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          state_d    = ST_OWN;
          gnt_d      = 4'b0001 << win_idx;
          owner_d    = win_idx;
          hold_cnt_d = 8'd0;
        end
      end
      ST_OWN: begin
        if (req[owner_q]) begin
          // Owner still requesting: load every cycle, release at the hold limit.
          q_d     = owner_din;
          q_vld_d = 1'b1;
          if (hold_cnt_q == HOLD_LAST) begin
            state_d = ST_IDLE;
            gnt_d   = 4'b0000;
            ptr_d   = owner_q + 2'd1;
          end else begin
            hold_cnt_d = hold_cnt_q + 8'd1;
          end
        end else begin
          // Owner dropped its request: release without loading.
          state_d = ST_IDLE;
          gnt_d   = 4'b0000;
          ptr_d   = owner_q + 2'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = 4'b0000;
      end
    endcase
  end

  // State register with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      gnt_q      <= 4'b0000;
      owner_q    <= 2'd0;
      q_q        <= '0;
      q_vld_q    <= 1'b0;
      ptr_q      <= 2'd0;
      hold_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      owner_q    <= owner_d;
      q_q        <= q_d;
      q_vld_q    <= q_vld_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign gnt   = gnt_q;
  assign owner = owner_q;
  assign q     = q_q;
  assign q_vld = q_vld_q;
  assign busy  = (state_q == ST_OWN);

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// tb/tb_shared_reg_arbiter.sv - directed vector bench for shared_reg_arbiter
module tb_shared_reg_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] din;

  logic [3:0]  gnt,   gnt2;
  logic [1:0]  owner, owner2;
  logic [7:0]  q,     q2;
  logic        q_vld, q_vld2;
  logic        busy,  busy2;

  int total;
  int bad;

  shared_reg_arbiter #(.DW(8), .MAX_HOLD(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .req(req), .din(din),
    .gnt(gnt), .owner(owner), .q(q), .q_vld(q_vld), .busy(busy)
  );

  shared_reg_arbiter #(.DW(8), .MAX_HOLD(2)) u_rr (
    .clk(clk), .rst_n(rst_n), .req(req), .din(din),
    .gnt(gnt2), .owner(owner2), .q(q2), .q_vld(q_vld2), .busy(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] din;
    logic [3:0]  gnt;
    logic [1:0]  owner;
    logic [7:0]  q;
    logic        vld;
    logic        busy;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 4'b0000;
    din   = 32'h0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    req   = 4'b0000;
    din   = 32'h0;

    // Reset with random inputs: outputs must stay cleared.
    for (int i = 0; i < 4; i++) begin
      req = 4'($urandom);
      din = $urandom;
      step();
      chk("rst_gnt",  32'(gnt),   32'h0);
      chk("rst_q",    32'(q),     32'h0);
      chk("rst_vld",  32'(q_vld), 32'h0);
      chk("rst_busy", 32'(busy),  32'h0);
      chk("rst_own",  32'(owner), 32'h0);
    end
    req   = 4'b0000;
    din   = 32'h0;
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("idle_gnt",  32'(gnt),   32'h0);
      chk("idle_q",    32'(q),     32'h0);
      chk("idle_vld",  32'(q_vld), 32'h0);
      chk("idle_busy", 32'(busy),  32'h0);
    end

    // Single requester then ignore-others, MAX_HOLD=4.
    tbl[0]  = '{4'b0100, 32'h00A50000, 4'b0100, 2'd2, 8'h00, 1'b0, 1'b1};
    tbl[1]  = '{4'b0100, 32'h00A50000, 4'b0100, 2'd2, 8'hA5, 1'b1, 1'b1};
    tbl[2]  = '{4'b0100, 32'h00A50000, 4'b0100, 2'd2, 8'hA5, 1'b1, 1'b1};
    tbl[3]  = '{4'b0000, 32'h00A50000, 4'b0000, 2'd2, 8'hA5, 1'b1, 1'b0};
    tbl[4]  = '{4'b0000, 32'h00000000, 4'b0000, 2'd2, 8'hA5, 1'b1, 1'b0};
    tbl[5]  = '{4'b1001, 32'h220000FF, 4'b1000, 2'd3, 8'hA5, 1'b1, 1'b1};
    tbl[6]  = '{4'b1000, 32'h330000FF, 4'b1000, 2'd3, 8'h33, 1'b1, 1'b1};
    tbl[7]  = '{4'b1001, 32'h440000FF, 4'b1000, 2'd3, 8'h44, 1'b1, 1'b1};
    tbl[8]  = '{4'b1001, 32'h550000FF, 4'b1000, 2'd3, 8'h55, 1'b1, 1'b1};
    tbl[9]  = '{4'b1001, 32'h660000FF, 4'b0000, 2'd3, 8'h66, 1'b1, 1'b0};
    tbl[10] = '{4'b0001, 32'h000000FF, 4'b0001, 2'd0, 8'h66, 1'b1, 1'b1};
    tbl[11] = '{4'b0000, 32'h000000FF, 4'b0000, 2'd0, 8'h66, 1'b1, 1'b0};
    for (int i = 0; i < 12; i++) begin
      req = tbl[i].req;
      din = tbl[i].din;
      step();
      chk($sformatf("v%0d_gnt", i),   32'(gnt),   32'(tbl[i].gnt));
      chk($sformatf("v%0d_owner", i), 32'(owner), 32'(tbl[i].owner));
      chk($sformatf("v%0d_q", i),     32'(q),     32'(tbl[i].q));
      chk($sformatf("v%0d_vld", i),   32'(q_vld), 32'(tbl[i].vld));
      chk($sformatf("v%0d_busy", i),  32'(busy),  32'(tbl[i].busy));
    end

    // Watchdog: requester 0 held for 10 edges, MAX_HOLD=4.
    do_reset();
    req = 4'b0001;
    for (int n = 1; n <= 10; n++) begin
      logic       exp_g;
      logic [7:0] exp_q;
      din   = 32'(n);
      exp_g = !(n == 5 || n == 10);
      if (n == 1)      exp_q = 8'd0;
      else if (n == 6) exp_q = 8'd5;
      else             exp_q = 8'(n);
      step();
      chk($sformatf("wd%0d_gnt", n),  32'(gnt),  exp_g ? 32'h1 : 32'h0);
      chk($sformatf("wd%0d_busy", n), 32'(busy), 32'(exp_g));
      chk($sformatf("wd%0d_q", n),    32'(q),    32'(exp_q));
    end

    // Round-robin with all requesting, MAX_HOLD=2 instance.
    do_reset();
    req = 4'b1111;
    din = 32'h13121110;
    for (int n = 1; n <= 13; n++) begin
      int         c, p;
      logic [3:0] exp_g;
      logic [7:0] exp_q;
      c = (n - 1) / 3;
      p = (n - 1) % 3;
      exp_g = (p < 2) ? (4'b0001 << (c % 4)) : 4'b0000;
      if (n == 1)      exp_q = 8'h00;
      else if (p == 0) exp_q = 8'(8'h10 + ((c - 1) % 4));
      else             exp_q = 8'(8'h10 + (c % 4));
      step();
      chk($sformatf("rr%0d_gnt", n),  32'(gnt2),  32'(exp_g));
      chk($sformatf("rr%0d_q", n),    32'(q2),    32'(exp_q));
      chk($sformatf("rr%0d_busy", n), 32'(busy2), 32'(exp_g != 4'b0000));
    end

    // Asynchronous reset while requester 1 owns the register.
    do_reset();
    req = 4'b0010;
    din = 32'h00007700;
    step();
    step();
    chk("ar_pre_gnt", 32'(gnt), 32'h2);
    chk("ar_pre_q",   32'(q),   32'h77);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_gnt",   32'(gnt),   32'h0);
    chk("ar_q",     32'(q),     32'h0);
    chk("ar_vld",   32'(q_vld), 32'h0);
    chk("ar_busy",  32'(busy),  32'h0);
    chk("ar_owner", 32'(owner), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    req   = 4'b1111;
    step();
    chk("ar_next_gnt",   32'(gnt),   32'h1);
    chk("ar_next_owner", 32'(owner), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
